// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one fixed-latency access at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default is fixed priority with MEM over IF.
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [DW/8-1:0] mem_be,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    output logic [DW-1:0]   mem_rdata,
    output logic            mem_ack,
    output logic            ram_en,
    output logic            ram_we,
    output logic [DW/8-1:0] ram_be,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata,
    output logic            stall_if,
    output logic            stall_mem
);

    localparam int BW = DW / 8;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    if (LAT < 1) begin : g_lat_check
        $error("mem_port_arbiter: LAT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_owner;        // 1 = MEM, 0 = IF; doubles as last owner for round-robin
    logic            r_we;
    logic [BW-1:0]   r_be;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [CW-1:0]   r_cnt;
    logic            r_if_ack;
    logic            r_mem_ack;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_mem_rdata;

    logic            w_if_elig;
    logic            w_mem_elig;
    logic            w_grant_mem;
    logic            w_ram_en;

    // A request still high in its own ack cycle has already been served.
    assign w_if_elig  = if_req  & ~r_if_ack;
    assign w_mem_elig = mem_req & ~r_mem_ack;

    always_comb begin
        w_grant_mem = w_mem_elig;
`ifdef MEM_ARB_RR_EN
        if (w_mem_elig && w_if_elig) begin
            w_grant_mem = ~r_owner;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ram_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_if_elig || w_mem_elig) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_ram_en    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_if_elig || w_mem_elig) begin
                        r_owner <= w_grant_mem;
                        if (w_grant_mem) begin
                            r_we    <= mem_we;
                            r_be    <= mem_be;
                            r_addr  <= mem_addr;
                            r_wdata <= mem_wdata;
                        end else begin
                            r_we    <= 1'b0;
                            r_be    <= '1;
                            r_addr  <= if_addr;
                            r_wdata <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= CW'(LAT - 1);
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_owner) begin
                            r_mem_ack <= 1'b1;
                            if (!r_we) begin
                                r_mem_rdata <= ram_rdata;
                            end
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= ram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory-side fields come straight from the latch so they hold between accesses.
    assign ram_en    = w_ram_en;
    assign ram_we    = r_we;
    assign ram_be    = r_be;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

    assign if_ack    = r_if_ack;
    assign mem_ack   = r_mem_ack;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign stall_if  = if_req  & ~r_if_ack;
    assign stall_mem = mem_req & ~r_mem_ack;

endmodule
